// File: rtl/data_pipe_1ton.sv
// data_pipe_1ton: packs NSIZE narrow beats (first beat in the top slice) into one wide word,
// buffered by a 2-entry first-word-fall-through queue. Optional early flush: DATA_PIPE_1TON_LAST_EN.
module data_pipe_1ton #(
   parameter int DSIZE = 1,
   parameter int NSIZE = 8
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic [DSIZE-1:0]       wr_data,
   input  logic                   wr_vld,
`ifdef DATA_PIPE_1TON_LAST_EN
   input  logic                   wr_last,
   output logic [NSIZE-1:0]       rd_keep,
`endif
   output logic                   wr_ready,
   output logic [DSIZE*NSIZE-1:0] rd_data,
   output logic                   rd_vld,
   input  logic                   rd_ready
);
   localparam int W  = DSIZE * NSIZE;
   localparam int PW = (NSIZE > 1) ? $clog2(NSIZE) : 1;
   localparam logic [PW-1:0] PTR_TOP = PW'(NSIZE - 1);

   logic [PW-1:0] ptr_r;
   logic [W-1:0]  acc_r;
   logic [W-1:0]  q0_data_r;
   logic [W-1:0]  q1_data_r;
   logic [1:0]    cnt_r;
   logic          vld_r;
   logic [W-1:0]  word_s;
   logic          last_s;
   logic          complete_s;
   logic          wr_fire_s;
   logic          push_s;
   logic          pop_s;

`ifdef DATA_PIPE_1TON_LAST_EN
   logic [NSIZE-1:0] q0_keep_r;
   logic [NSIZE-1:0] q1_keep_r;
   logic [NSIZE-1:0] keep_s;

   assign last_s  = wr_last;
   assign rd_keep = q0_keep_r;

   // Keep mask: every slice at or above the current pointer holds a received beat
   always_comb begin
      keep_s = '0;
      for (int i = 0; i < NSIZE; i++) begin
         keep_s[i] = (i >= int'(ptr_r)) ? 1'b1 : 1'b0;
      end
   end
`else
   assign last_s = 1'b0;
`endif

   assign complete_s = (ptr_r == '0) || last_s;
   // A completing beat needs a free queue slot; other beats only touch the accumulator
   assign wr_ready   = !rst && (!complete_s || (cnt_r < 2'd2));
   assign wr_fire_s  = wr_vld && wr_ready;
   assign push_s     = wr_fire_s && complete_s;
   assign pop_s      = vld_r && rd_ready;
   assign rd_data    = q0_data_r;
   assign rd_vld     = vld_r;

   // Accumulator with the incoming beat merged into its slice
   always_comb begin
      word_s = acc_r;
      word_s[DSIZE*int'(ptr_r) +: DSIZE] = wr_data;
   end

   // Slice pointer and partial-word accumulator
   always_ff @(posedge clock) begin
      if (rst) begin
         ptr_r <= PTR_TOP;
         acc_r <= '0;
      end else if (wr_fire_s) begin
         if (complete_s) begin
            ptr_r <= PTR_TOP;
            acc_r <= '0;
         end else begin
            ptr_r <= ptr_r - PW'(1);
            acc_r <= word_s;
         end
      end else begin
         ptr_r <= ptr_r;
         acc_r <= acc_r;
      end
   end

   // Output queue; the unused tail is held at zero so an empty head reads as zero
   always_ff @(posedge clock) begin
      if (rst) begin
         q0_data_r <= '0;
         q1_data_r <= '0;
         cnt_r     <= 2'd0;
         vld_r     <= 1'b0;
`ifdef DATA_PIPE_1TON_LAST_EN
         q0_keep_r <= '0;
         q1_keep_r <= '0;
`endif
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (cnt_r == 2'd0) begin
                  q0_data_r <= word_s;
`ifdef DATA_PIPE_1TON_LAST_EN
                  q0_keep_r <= keep_s;
`endif
               end else begin
                  q1_data_r <= word_s;
`ifdef DATA_PIPE_1TON_LAST_EN
                  q1_keep_r <= keep_s;
`endif
               end
               cnt_r <= cnt_r + 2'd1;
               vld_r <= 1'b1;
            end
            2'b01: begin
               q0_data_r <= q1_data_r;
               q1_data_r <= '0;
`ifdef DATA_PIPE_1TON_LAST_EN
               q0_keep_r <= q1_keep_r;
               q1_keep_r <= '0;
`endif
               cnt_r <= cnt_r - 2'd1;
               vld_r <= (cnt_r == 2'd2);
            end
            2'b11: begin
               // Only reachable with one entry: the head is replaced, occupancy unchanged
               q0_data_r <= word_s;
`ifdef DATA_PIPE_1TON_LAST_EN
               q0_keep_r <= keep_s;
`endif
            end
            default: begin
               cnt_r <= cnt_r;
               vld_r <= vld_r;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_pipe_1ton.sv
// Bench for data_pipe_1ton: directed table/sequences plus randomized traffic against a
// queue-based reference model (DSIZE=8, NSIZE=4; NSIZE=1 on a second instance).
module tb_data_pipe_1ton;
   localparam int NSIZE = 4;
`ifdef DATA_PIPE_1TON_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_vld = 1'b0;
   logic        wr_last = 1'b0;
   logic        rd_ready = 1'b0;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_vld;
   logic [3:0]  rd_keep;

   logic [7:0]  u1_wr_data = 8'h00;
   logic        u1_wr_vld = 1'b0;
   logic        u1_wr_last = 1'b0;
   logic        u1_rd_ready = 1'b0;
   logic        u1_wr_ready;
   logic [7:0]  u1_rd_data;
   logic        u1_rd_vld;
   logic [0:0]  u1_rd_keep;

   always #5 clock = ~clock;

   data_pipe_1ton #(.DSIZE(8), .NSIZE(NSIZE)) dut (
      .clock(clock), .rst(rst), .wr_data(wr_data), .wr_vld(wr_vld),
`ifdef DATA_PIPE_1TON_LAST_EN
      .wr_last(wr_last), .rd_keep(rd_keep),
`endif
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_vld(rd_vld), .rd_ready(rd_ready)
   );

   data_pipe_1ton #(.DSIZE(8), .NSIZE(1)) dut1 (
      .clock(clock), .rst(rst), .wr_data(u1_wr_data), .wr_vld(u1_wr_vld),
`ifdef DATA_PIPE_1TON_LAST_EN
      .wr_last(u1_wr_last), .rd_keep(u1_rd_keep),
`endif
      .wr_ready(u1_wr_ready), .rd_data(u1_rd_data), .rd_vld(u1_rd_vld), .rd_ready(u1_rd_ready)
   );

`ifndef DATA_PIPE_1TON_LAST_EN
   assign rd_keep    = 4'b0000;
   assign u1_rd_keep = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int words_out = 0;
   int accepted  = 0;

   logic [7:0]  part[$];
   logic [31:0] mq_data[$];
   logic [3:0]  mq_keep[$];

   logic        s_wr_ready, s_rd_vld;
   logic [31:0] s_rd_data;
   logic [3:0]  s_rd_keep;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rr;
      logic        exp_vld;
      logic [31:0] exp_data;
      logic        exp_rdy;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One clock cycle on the main instance: drive, check against the model, advance the model.
   task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic rr,
                        input logic r);
      logic        comp, exp_rdy;
      logic [31:0] w;
      logic [3:0]  k;
      wr_vld = v; wr_data = d; wr_last = l; rd_ready = rr; rst = r;
      @(negedge clock);
      comp    = (part.size() == NSIZE - 1) || (LAST_EN && l);
      exp_rdy = !r && !(comp && mq_data.size() == 2);
      chk("wr_ready", {63'd0, wr_ready}, {63'd0, exp_rdy});
      chk("rd_vld", {63'd0, rd_vld}, {63'd0, mq_data.size() != 0});
      chk("rd_data", {32'd0, rd_data}, {32'd0, (mq_data.size() != 0) ? mq_data[0] : 32'd0});
      if (LAST_EN)
         chk("rd_keep", {60'd0, rd_keep}, {60'd0, (mq_keep.size() != 0) ? mq_keep[0] : 4'd0});
      s_wr_ready = wr_ready; s_rd_vld = rd_vld; s_rd_data = rd_data; s_rd_keep = rd_keep;
      if (r) begin
         part.delete(); mq_data.delete(); mq_keep.delete();
      end else begin
         if (mq_data.size() != 0 && rr) begin
            void'(mq_data.pop_front());
            void'(mq_keep.pop_front());
            words_out++;
         end
         if (v && exp_rdy) begin
            accepted++;
            part.push_back(d);
            if (comp) begin
               w = 32'd0; k = 4'd0;
               for (int i = 0; i < part.size(); i++) begin
                  w = w | (32'(part[i]) << (8 * (NSIZE - 1 - i)));
                  k[NSIZE-1-i] = 1'b1;
               end
               mq_data.push_back(w);
               mq_keep.push_back(k);
               part.delete();
            end
         end
      end
      @(posedge clock); #1;
   endtask

   initial begin
      int w0, idx, got;
      logic all_ready;
      logic [31:0] cap;

      tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 32'h0, 1'b1};
      tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 32'h0, 1'b1};
      tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 32'h0, 1'b1};
      tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b0, 32'h0, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h11223344, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b1};

      rst = 1'b1;
      @(posedge clock); #1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("reset_wr_ready_low", {63'd0, s_wr_ready}, 64'd0);

      // Basic pack
      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].v, tbl[i].d, 1'b0, tbl[i].rr, 1'b0);
         chk("tbl_vld", {63'd0, s_rd_vld}, {63'd0, tbl[i].exp_vld});
         chk("tbl_rdy", {63'd0, s_wr_ready}, {63'd0, tbl[i].exp_rdy});
         if (tbl[i].exp_vld) chk("tbl_data", {32'd0, s_rd_data}, {32'd0, tbl[i].exp_data});
      end

      // Back-to-back throughput
      w0 = words_out; all_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
         if (!s_wr_ready) all_ready = 1'b0;
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("b2b_ready_const", {63'd0, all_ready}, 64'd1);
      chk("b2b_words", 64'(words_out - w0), 64'd4);

      // Backpressure
      w0 = words_out; idx = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 8'h80 + 8'(idx), 1'b0, 1'b0, 1'b0);
         if (s_wr_ready) idx++;
      end
      chk("bp_accepted", 64'(idx), 64'd11);
      chk("bp_ready_low", {63'd0, s_wr_ready}, 64'd0);
      cycle(1'b1, 8'h80 + 8'(idx), 1'b0, 1'b1, 1'b0);
      chk("bp_ready_in_pop_cycle", {63'd0, s_wr_ready}, 64'd0);
      cycle(1'b1, 8'h80 + 8'(idx), 1'b0, 1'b1, 1'b0);
      chk("bp_ready_after_pop", {63'd0, s_wr_ready}, 64'd1);
      if (s_wr_ready) idx++;
      for (int i = 0; i < 40 && idx < 16; i++) begin
         cycle(1'b1, 8'h80 + 8'(idx), 1'b0, 1'b1, 1'b0);
         if (s_wr_ready) idx++;
      end
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("bp_all_beats", 64'(idx), 64'd16);
      chk("bp_words", 64'(words_out - w0), 64'd4);

      // Reset mid-word
      w0 = words_out; cap = 32'd0;
      cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("rst_vld", {63'd0, s_rd_vld}, 64'd0);
      chk("rst_data", {32'd0, s_rd_data}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1, 1'b0);
         if (i == 0) chk("rst_release_ready", {63'd0, s_wr_ready}, 64'd1);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         if (s_rd_vld) cap = s_rd_data;
      end
      chk("rst_word", {32'd0, cap}, {32'd0, 32'hA0A1A2A3});
      chk("rst_words", 64'(words_out - w0), 64'd1);

      // Gaps
      cap = 32'd0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'h5A + 8'(i), 1'b0, 1'b1, 1'b0);
         cycle(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
         if (s_rd_vld) cap = s_rd_data;
      end
      chk("gap_word", {32'd0, cap}, {32'd0, 32'h5A5B5C5D});

      // NSIZE=1 instance
      u1_rd_ready = 1'b1; u1_wr_vld = 1'b1; u1_wr_data = 8'h01;
      @(negedge clock);
      chk("n1_c0_vld", {63'd0, u1_rd_vld}, 64'd0);
      chk("n1_c0_rdy", {63'd0, u1_wr_ready}, 64'd1);
      @(posedge clock); #1;
      u1_wr_data = 8'h02;
      @(negedge clock);
      chk("n1_c1_vld", {63'd0, u1_rd_vld}, 64'd1);
      chk("n1_c1_data", {56'd0, u1_rd_data}, 64'h01);
      chk("n1_c1_rdy", {63'd0, u1_wr_ready}, 64'd1);
      @(posedge clock); #1;
      u1_wr_vld = 1'b0;
      @(negedge clock);
      chk("n1_c2_vld", {63'd0, u1_rd_vld}, 64'd1);
      chk("n1_c2_data", {56'd0, u1_rd_data}, 64'h02);
      @(posedge clock); #1;
      @(negedge clock);
      chk("n1_c3_vld", {63'd0, u1_rd_vld}, 64'd0);
      @(posedge clock); #1;

`ifdef DATA_PIPE_1TON_LAST_EN
      // Early flush
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("flush_data", {32'd0, s_rd_data}, {32'd0, 32'h55660000});
      chk("flush_keep", {60'd0, s_rd_keep}, 64'hC);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h01 + 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("full_data", {32'd0, s_rd_data}, {32'd0, 32'h01020304});
      chk("full_keep", {60'd0, s_rd_keep}, 64'hF);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, 8'($urandom),
               $urandom_range(0, 7) == 0,
               (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
               $urandom_range(0, 299) == 0);
      end
      got = 0;
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("drain_empty", 64'(mq_data.size()), 64'(got));
      chk("random_words_seen", {63'd0, words_out > 20}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
